mem_bank: RTL and testbench
===========================

# mem_bank

Parametrised single-port synchronous memory bank with a valid/ready request interface, per-byte write enables, a selectable 1- or 2-cycle read pipeline and an optional post-reset clear sweep. It replaces the fixed 4096×32 word memory as the CPU's instruction/data store. The core or bus adapter issues one request per cycle; read data returns on a separate valid-qualified response port.

## Interface
- `DATA_W`, 32: word width in bits; must be a multiple of 8.
- `ADDR_W`, 12: address width; depth is `DEPTH = 2**ADDR_W` words.
- `READ_LAT`, 1: read latency in cycles; legal values are 1 or 2.
- `clk` in 1: clock; all logic is on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: bank can accept a request this cycle.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in `ADDR_W`: word address.
- `req_wdata` in `DATA_W`: write data.
- `req_be` in `DATA_W/8`: byte enables; bit i enables byte i (bits 8i+7:8i).
- `rsp_valid` out 1: `rsp_rdata` holds read data this cycle.
- `rsp_rdata` out `DATA_W`: read data.

## Operation
- A request is accepted at a rising edge where `req_valid && req_ready`.
- Accepted write:
  - Each byte with `req_be[i]=1` is updated at that edge; other bytes keep their value.
  - `be=0` writes nothing.
  - Writes produce no response.
- Accepted read:
  - Returns the word at `req_addr` on `rsp_rdata`, with `rsp_valid` high for exactly one cycle.
  - There is no response backpressure; the consumer must take data in the valid cycle.
- Throughput: one request per cycle, reads and writes in any mix.
- A read accepted the cycle after a write to the same address returns the new data, because the write completes at its accept edge.
- `rsp_rdata` holds its last value while `rsp_valid` is 0.
- Control FSM states are `INIT` and `READY`. `rst` forces `INIT`.
  - With the clear sweep compiled in, `INIT` lasts `DEPTH` cycles (see Configuration).
  - Without it, `INIT` lasts one cycle.
  - `req_ready = (state == READY)`, registered.
- Reset values: `req_ready=0`, `rsp_valid=0`, `rsp_rdata=0`, all pipeline valid bits 0, sweep counter 0.
- Reset mid-operation flushes in-flight reads; no `rsp_valid` appears for them.
- Reset does not touch array contents unless the sweep is enabled.

## Timing
- `READ_LAT=1`: data is registered from the array at the accept edge; `rsp_valid` is high in the cycle after acceptance.
- `READ_LAT=2`: an extra output register is added; `rsp_valid` is high two cycles after acceptance.
- Back-to-back reads give back-to-back `rsp_valid` pulses.
- Without the sweep, `req_ready` rises at the first edge where `rst=0`.
- `req_ready` falls at the edge where `rst` is sampled high.

## Configuration
- Macro: `MEM_BANK_CLEAR_ON_RESET_EN`.
- Defined:
  - In `INIT`, each edge with `rst=0` writes 0 to address `cnt` and increments `cnt`.
  - At the edge writing `DEPTH-1`, the FSM moves to `READY`; `req_ready` is high after edge `DEPTH` counted from the first `rst=0` edge.
  - Reasserting `rst` during the sweep restarts it at 0.
- Not defined: no counter, and array contents after reset are undefined (X in simulation).

## Structure
- Package `mem_bank_pkg` holds the state enum (`INIT`, `READY`) and localparams `BE_W = DATA_W/8` and `DEPTH`.
- Sub-module `mem_bank_array` is the raw single-port array with byte-enable write and a registered read, with no reset.
- `mem_bank` holds the FSM, sweep counter, read pipeline and handshake.

## Test plan
- Reset, then write 0xDEADBEEF to address 0x005 with `be=4'hF`, then read 0x005. Required: `rsp_rdata=0xDEADBEEF` with `rsp_valid` exactly `READ_LAT` cycles after acceptance.
- Byte enables: write 0x11223344 to address 7, then write 0xAABBCCDD with `be=4'b0101`, then read address 7. Required: `0x11BB33DD`.
- Stream reads to addresses 0..15 on consecutive cycles after preloading data = address×3. Required: 16 consecutive `rsp_valid` pulses, data 0, 3, …, 45, in order.
- With `MEM_BANK_CLEAR_ON_RESET_EN` and `ADDR_W=4`: hold `rst` for 2 cycles. Required: `req_ready` stays 0 for 16 cycles after `rst` falls; any read afterwards returns 0.
- Accept a read at 0x010 (`READ_LAT=2`), then assert `rst` the next cycle. Required: no `rsp_valid` appears; `req_ready=0` until the FSM re-enters `READY`.
- Write with `be=0` to address 3, which holds 0x12345678, then read address 3. Required: 0x12345678 unchanged.

Source files
------------

// File: rtl/mem_bank_pkg.sv
// Shared types and default geometry for the mem_bank memory slice.
package mem_bank_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 12;
  localparam int unsigned BE_W       = DEF_DATA_W / 8;
  localparam int unsigned DEPTH      = 2 ** DEF_ADDR_W;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

endpackage

// File: rtl/mem_bank_array.sv
// Raw single-port word array: byte-enable write and a registered read, no reset.
module mem_bank_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   be,
  output logic [DATA_W-1:0]     rdata
);

  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned NW = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [NW];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_bank.sv
// Memory bank top: INIT/READY control, optional clear sweep, 1- or 2-cycle read pipeline.
// Build option: define MEM_BANK_CLEAR_ON_RESET_EN to zero the array after every reset.
module mem_bank #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned READ_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata
);

  import mem_bank_pkg::*;

  localparam int unsigned NB = DATA_W / 8;

  state_t              state_q, state_d;
  logic                accept_c, rd_acc_c;
  logic                arr_we;
  logic [ADDR_W-1:0]   arr_addr;
  logic [DATA_W-1:0]   arr_wdata;
  logic [NB-1:0]       arr_be;
  logic [DATA_W-1:0]   arr_rdata;
  logic                rd_v1_q;

  assign accept_c = req_valid & req_ready & ~rst;
  assign rd_acc_c = accept_c & ~req_we;

`ifdef MEM_BANK_CLEAR_ON_RESET_EN
  logic [ADDR_W-1:0] cnt_q;

  // Sweep address; restarts from 0 on every reset.
  always_ff @(posedge clk) begin
    if (rst)                  cnt_q <= '0;
    else if (state_q == INIT) cnt_q <= cnt_q + 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= INIT;
    else     state_q <= state_d;
  end

  // Next state and array port steering (sweep owns the port while in INIT).
  always_comb begin
    state_d   = state_q;
    arr_we    = accept_c & req_we;
    arr_addr  = req_addr;
    arr_wdata = req_wdata;
    arr_be    = req_be;
    case (state_q)
      INIT: begin
`ifdef MEM_BANK_CLEAR_ON_RESET_EN
        arr_we    = ~rst;
        arr_addr  = cnt_q;
        arr_wdata = '0;
        arr_be    = '1;
        if (cnt_q == '1) state_d = READY;
`else
        state_d = READY;
`endif
      end
      READY:   state_d = READY;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready <= 1'b0;
      rd_v1_q   <= 1'b0;
    end else begin
      req_ready <= (state_d == READY);
      rd_v1_q   <= rd_acc_c;
    end
  end

  mem_bank_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (rd_acc_c),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .be    (arr_be),
    .rdata (arr_rdata)
  );

  if (READ_LAT == 2) begin : g_lat2
    logic              rd_v2_q;
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_v2_q <= 1'b0;
        rdata_q <= '0;
      end else begin
        rd_v2_q <= rd_v1_q;
        if (rd_v1_q) rdata_q <= arr_rdata;
      end
    end

    assign rsp_valid = rd_v2_q;
    assign rsp_rdata = rdata_q;
  end else begin : g_lat1
    // Array output register has no reset; hide it until the first read loads it.
    logic seen_q;

    always_ff @(posedge clk) begin
      if (rst)           seen_q <= 1'b0;
      else if (rd_acc_c) seen_q <= 1'b1;
    end

    assign rsp_valid = rd_v1_q;
    assign rsp_rdata = seen_q ? arr_rdata : '0;
  end

endmodule

// File: tb/tb_mem_bank.sv
// Scoreboard bench: the same request stream drives a READ_LAT=1 and a READ_LAT=2 bank.
module tb_mem_bank;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 12;
  localparam int NW = 1 << AW;
`ifdef MEM_BANK_CLEAR_ON_RESET_EN
  localparam int RDY_EDGES = NW;
`else
  localparam int RDY_EDGES = 1;
`endif

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [3:0]    req_be = '0;
  logic          ready1, ready2, valid1, valid2;
  logic [DW-1:0] rdata1, rdata2;

  exp_t q1[$];
  exp_t q2[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_bank #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready1), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(valid1), .rsp_rdata(rdata1)
  );

  mem_bank #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready2), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(valid2), .rsp_rdata(rdata2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic issue_wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; req_be = be;
  endtask

  // Accept happens at the next edge; LAT=1 response is seen one negedge later, LAT=2 two.
  task automatic issue_rd(input logic [AW-1:0] a, input logic [31:0] exp, input bit lat2_resp);
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = '0; req_be = '0;
    e.data = exp;
    e.due  = cyc + 1;
    q1.push_back(e);
    if (lat2_resp) begin
      e.due = cyc + 2;
      q2.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready1 && n < NW + 8);
    check(name, 32'(n), 32'(RDY_EDGES));
    check({name, "_lat2"}, 32'(ready2), 32'd1);
  endtask

  always @(negedge clk) begin : mon1
    exp_t e;
    if (valid1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL rsp1_unexpected actual=%h required=no response", rdata1);
      end else begin
        e = q1.pop_front();
        check("rsp1_data", rdata1, e.data);
        check("rsp1_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (valid2) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL rsp2_unexpected actual=%h required=no response", rdata2);
      end else begin
        e = q2.pop_front();
        check("rsp2_data", rdata2, e.data);
        check("rsp2_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready1", 32'(ready1), 32'd0);
    check("rst_ready2", 32'(ready2), 32'd0);
    check("rst_valid1", 32'(valid1), 32'd0);
    check("rst_valid2", 32'(valid2), 32'd0);
    check("rst_rdata1", rdata1, 32'd0);
    check("rst_rdata2", rdata2, 32'd0);
    rst = 1'b0;
    wait_ready("ready_rise");

`ifdef MEM_BANK_CLEAR_ON_RESET_EN
    issue_rd(12'h005, 32'h0, 1'b1);
`endif
    issue_wr(12'h005, 32'hDEADBEEF, 4'hF);
    issue_rd(12'h005, 32'hDEADBEEF, 1'b1);

    issue_wr(12'h007, 32'h11223344, 4'hF);
    issue_wr(12'h007, 32'hAABBCCDD, 4'b0101);
    issue_rd(12'h007, 32'h11BB33DD, 1'b1);

    for (int i = 0; i < 16; i++) issue_wr(12'(i), 32'(i * 3), 4'hF);
    for (int i = 0; i < 16; i++) issue_rd(12'(i), 32'(i * 3), 1'b1);

    issue_wr(12'h003, 32'h12345678, 4'hF);
    issue_wr(12'h003, 32'hFFFFFFFF, 4'h0);
    issue_rd(12'h003, 32'h12345678, 1'b1);

    idle(4);
    check("hold_valid1", 32'(valid1), 32'd0);
    check("hold_rdata1", rdata1, 32'h12345678);
    check("hold_rdata2", rdata2, 32'h12345678);

    // Reset one cycle after a read is accepted: only the LAT=1 bank has already answered.
    issue_wr(12'h020, 32'hCAFEF00D, 4'hF);
    issue_wr(12'h010, 32'h0BADF00D, 4'hF);
    issue_rd(12'h010, 32'h0BADF00D, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("flush_ready1", 32'(ready1), 32'd0);
    check("flush_ready2", 32'(ready2), 32'd0);
    rst = 1'b0;
    wait_ready("ready_after_flush");

`ifdef MEM_BANK_CLEAR_ON_RESET_EN
    issue_rd(12'h020, 32'h0, 1'b1);
`else
    issue_rd(12'h020, 32'hCAFEF00D, 1'b1);
`endif
    idle(6);
    check("drain_q1", 32'(q1.size()), 32'd0);
    check("drain_q2", 32'(q2.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
